// File: rtl/param_reg.sv
// -----------------------------------------------------------------------------
// param_reg
//   Generic WIDTH-bit state register with write enable, per-bit write mask and
//   synchronous clear. Used for architectural state such as the program
//   counter (WIDTH=32, RESET_VAL=32'h8000_0000, wen tied high, din = dout + 4).
//
// Parameters
//   WIDTH      data width in bits, legal range 1..64
//   RESET_VAL  value loaded on asynchronous reset and on synchronous clear
//
// Ports
//   clk    in   1      clock, all updates on the rising edge
//   rst    in   1      asynchronous active-low reset
//   din    in   WIDTH  write data
//   wen    in   1      write enable
//   wmask  in   WIDTH  per-bit write mask, 1 = bit written
//   clr    in   1      synchronous clear to RESET_VAL (beats wen)
//   dout   out  WIDTH  registered value
//   perr   out  1      parity error, only when PARAM_REG_PARITY_EN is defined
//   upd    out  1      registered pulse: dout changed on the last edge
//
// Build option
//   PARAM_REG_PARITY_EN  adds a stored even-parity bit and the perr output.
// -----------------------------------------------------------------------------
module param_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic [WIDTH-1:0] wmask,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
`ifdef PARAM_REG_PARITY_EN
  output logic             perr,
`endif
  output logic             upd
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             upd_q, upd_d;

  // clr has priority; with neither clr nor wen, din and wmask are ignored.
  always_comb begin
    dout_d = dout_q;
    if (clr) begin
      dout_d = RESET_VAL;
    end else if (wen) begin
      dout_d = (din & wmask) | (dout_q & ~wmask);
    end
    // A write of the current value, or a clear at RESET_VAL, is not an update.
    upd_d = (dout_d != dout_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= RESET_VAL;
      upd_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      upd_q  <= upd_d;
    end
  end

  assign dout = dout_q;
  assign upd  = upd_q;

`ifdef PARAM_REG_PARITY_EN
  logic par_q, par_d;

  // Parity is taken from the post-mask value so it always tracks dout_q.
  always_comb begin
    par_d = par_q;
    if (clr || wen) begin
      par_d = ^dout_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  // Nonzero only if stored data or the parity bit was upset.
  assign perr = (^dout_q) ^ par_q;
`endif

endmodule

// File: tb/tb_param_reg.sv
module tb_param_reg;

  localparam int unsigned W  = 32;
  localparam logic [W-1:0] RV = 32'h8000_0000;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         wen;
  logic [W-1:0] wmask;
  logic         clr;
  logic [W-1:0] dout;
  logic         upd;
`ifdef PARAM_REG_PARITY_EN
  logic         perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural reference: value and "changed" flag derived from the rules.
  logic [W-1:0] m_dout;
  logic         m_upd;

  param_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wen   (wen),
    .wmask (wmask),
    .clr   (clr),
    .dout  (dout),
`ifdef PARAM_REG_PARITY_EN
    .perr  (perr),
`endif
    .upd   (upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    logic [W-1:0] nxt;
    if (!rst) begin
      m_dout = RV;
      m_upd  = 1'b0;
    end else begin
      if (clr)      nxt = RV;
      else if (wen) nxt = (din & wmask) | (m_dout & ~wmask);
      else          nxt = m_dout;
      m_upd  = (nxt != m_dout);
      m_dout = nxt;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (dout !== m_dout) begin
        n_bad++;
        $display("FAIL model_dout t=%0t got %h want %h", $time, dout, m_dout);
      end
      n_cmp++;
      if (upd !== m_upd) begin
        n_bad++;
        $display("FAIL model_upd t=%0t got %b want %b", $time, upd, m_upd);
      end
`ifdef PARAM_REG_PARITY_EN
      n_cmp++;
      if (perr !== 1'b0) begin
        n_bad++;
        $display("FAIL perr t=%0t got %b want 0", $time, perr);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    din   = '0;
    wen   = 1'b0;
    wmask = ONES;
    clr   = 1'b0;

    // Mid-cycle asynchronous reset (first posedge at t=5).
    #2 rst = 1'b0;
    #1;
    check("reset_dout", dout, RV);
    check("reset_upd", {31'd0, upd}, 32'd0);
    chk_en = 1'b1;
    tick();
    check("reset_held", dout, RV);

    // Set up a write, release mid-cycle: value must hold until the next edge.
    wen = 1'b1;
    din = m_dout + 32'd4;
    #2 rst = 1'b1;
    #1;
    check("release_hold", dout, RV);

    // PC increment.
    tick();
    check("pc1", dout, 32'h8000_0004);
    check("pc1_upd", {31'd0, upd}, 32'd1);
    din = m_dout + 32'd4;
    tick();
    check("pc2", dout, 32'h8000_0008);
    din = m_dout + 32'd4;
    tick();
    check("pc3", dout, 32'h8000_000C);
    check("pc3_upd", {31'd0, upd}, 32'd1);

    // Identical write is not an update.
    din = 32'h8000_000C;
    tick();
    check("same_upd", {31'd0, upd}, 32'd0);

    // Hold with garbage on din.
    wen = 1'b0;
    din = 32'hDEAD_BEEF;
    tick();
    tick();
    check("hold_dout", dout, 32'h8000_000C);
    check("hold_upd", {31'd0, upd}, 32'd0);

    // Clear back to RESET_VAL, then masked write.
    clr = 1'b1;
    tick();
    check("clr_dout", dout, RV);
    clr   = 1'b0;
    wen   = 1'b1;
    din   = 32'h1234_5678;
    wmask = 32'h0000_FFFF;
    tick();
    check("mask_dout", dout, 32'h8000_5678);
    check("mask_upd", {31'd0, upd}, 32'd1);

    // Upper-half mask on top of that.
    din   = 32'hABCD_0000;
    wmask = 32'hFFF0_0000;
    tick();
    check("mask2_dout", dout, 32'hABC0_5678);

    // Clear priority over write.
    wmask = ONES;
    clr   = 1'b1;
    din   = '0;
    tick();
    check("clrpri_dout", dout, RV);
    check("clrpri_upd", {31'd0, upd}, 32'd1);
    tick();
    check("clr_again_upd", {31'd0, upd}, 32'd0);
    check("clr_again_dout", dout, RV);
    clr = 1'b0;

    // Wrap past all-ones.
    din = 32'hFFFF_FFFC;
    tick();
    check("pre_wrap", dout, 32'hFFFF_FFFC);
    din = m_dout + 32'd4;
    tick();
    check("wrap_dout", dout, 32'h0000_0000);
    check("wrap_upd", {31'd0, upd}, 32'd1);

    // Async abort of a pending write.
    din = 32'hFFFF_FFFC;
    tick();
    din = m_dout + 32'd4;
    #2 rst = 1'b0;
    #1;
    check("abort_now", dout, RV);
    check("abort_upd", {31'd0, upd}, 32'd0);
    tick();
    check("abort_edge", dout, RV);
    wen = 1'b0;
    #2 rst = 1'b1;
    tick();
    check("abort_after", dout, RV);
    check("abort_after_upd", {31'd0, upd}, 32'd0);

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
